rep_seq_checker: RTL and testbench

Synthesisable multi-channel repetition checker: the hardware counterpart of the team's non-consecutive (`[=m:n]`) and go-to (`[->m:n]`) assertion checks. Each channel watches a trigger rising edge and counts occurrences of an event within a bounded window. It reports pass or fail with a cause code. It sits beside DUT interfaces as an on-chip protocol monitor, for emulation and silicon debug, where SVA is unavailable.

---
 rtl/rep_chk_pkg.sv | 30 +++
 rtl/rep_chk_chan.sv | 122 ++++++++++++
 rtl/rep_seq_checker.sv | 86 ++++++++
 tb/tb_rep_seq_checker.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rep_chk_pkg.sv
// Shared types and width helpers for the rep_seq_checker repetition monitor.
package rep_chk_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    UNDER = 2'd1,
    OVER  = 2'd2,
    QUAL  = 2'd3
  } fail_code_e;

  typedef enum logic {
    NONCONSEC = 1'b0,
    GOTO      = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // The event count must be able to hold MAX_CNT+1 so an overcount is observable.
  function automatic int cnt_width(input int max_cnt);
    return $clog2(max_cnt + 2);
  endfunction

  function automatic int win_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/rep_chk_chan.sv
// One repetition-check channel: trigger edge detect, IDLE/ACTIVE attempt FSM, event and window counters.
// Qualifier ("throughout") checking is compiled in only when REP_CHK_QUAL_EN is defined.
module rep_chk_chan
  import rep_chk_pkg::*;
#(
  parameter  int MIN_CNT = 3,
  parameter  int MAX_CNT = 5,
  parameter  int WINDOW  = 16,
  localparam int CNT_W   = cnt_width(MAX_CNT),
  localparam int WIN_W   = win_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_trig,
  input  logic             i_ev,
  input  logic             i_qual,
  input  logic             i_mode,
  output logic             o_busy,
  output logic             o_pass,
  output logic             o_fail,
  output fail_code_e       o_fail_code,
  output logic             o_ovl,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(MAX_CNT + 1);
  localparam logic [WIN_W-1:0] WIN_END  = WIN_W'(WINDOW);

  state_e           r_state, w_state_nxt;
  mode_e            r_mode, w_mode_nxt, w_mode_eff;
  fail_code_e       r_code, w_code_nxt;
  logic             r_trig_q;
  logic             r_pass, w_pass_nxt;
  logic             r_fail, w_fail_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_base, w_cnt_step;
  logic [WIN_W-1:0] r_win, w_win_nxt, w_win_step;
  logic             w_rise, w_start, w_run, w_qual_drop;

  assign w_rise  = i_trig & ~r_trig_q;
  assign w_start = (r_state == IDLE) & w_rise;
  assign w_run   = w_start | (r_state == ACTIVE);

`ifdef REP_CHK_QUAL_EN
  assign w_qual_drop = w_run & ~i_qual;
`else
  logic w_unused_qual;
  assign w_unused_qual = i_qual;
  assign w_qual_drop   = 1'b0;
`endif

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mode   <= NONCONSEC;
      r_code   <= NONE;
      r_trig_q <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_cnt    <= '0;
      r_win    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_code   <= w_code_nxt;
      r_trig_q <= i_trig;
      r_pass   <= w_pass_nxt;
      r_fail   <= w_fail_nxt;
      r_cnt    <= w_cnt_nxt;
      r_win    <= w_win_nxt;
    end
  end

  // The start cycle is evaluated like an ACTIVE cycle, with counters seeded from zero.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_win_nxt   = r_win;
    w_pass_nxt  = 1'b0;
    w_fail_nxt  = 1'b0;
    w_code_nxt  = NONE;
    w_mode_eff  = w_start ? mode_e'(i_mode) : r_mode;
    w_cnt_base  = w_start ? '0 : r_cnt;
    w_win_step  = (w_start ? '0 : r_win) + WIN_W'(1);
    w_cnt_step  = (w_cnt_base == CNT_OVER) ? w_cnt_base : w_cnt_base + CNT_W'(i_ev);

    if (w_run) begin
      w_state_nxt = ACTIVE;
      w_mode_nxt  = w_mode_eff;
      w_cnt_nxt   = w_cnt_step;
      w_win_nxt   = w_win_step;
      if (w_qual_drop) begin
        w_fail_nxt = 1'b1;
        w_code_nxt = QUAL;
      end else if (w_mode_eff == NONCONSEC && w_cnt_step == CNT_OVER) begin
        w_fail_nxt = 1'b1;
        w_code_nxt = OVER;
      end else if (w_mode_eff == GOTO && w_cnt_step == CNT_MIN) begin
        w_pass_nxt = 1'b1;
      end else if (w_win_step == WIN_END) begin
        if (w_mode_eff == NONCONSEC && w_cnt_step >= CNT_MIN) begin
          w_pass_nxt = 1'b1;
        end else begin
          w_fail_nxt = 1'b1;
          w_code_nxt = UNDER;
        end
      end
      if (w_pass_nxt || w_fail_nxt) w_state_nxt = IDLE;
    end
  end

  assign o_busy      = (r_state == ACTIVE);
  assign o_ovl       = (r_state == ACTIVE) & w_rise;
  assign o_pass      = r_pass;
  assign o_fail      = r_fail;
  assign o_fail_code = r_code;
  assign o_cnt       = r_cnt;

endmodule

// File: rtl/rep_seq_checker.sv
// Multi-channel repetition checker: NCH independent rep_chk_chan instances plus saturating totals.
// Define REP_CHK_QUAL_EN to enable qualifier checking (fail code 3).
module rep_seq_checker
  import rep_chk_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int MIN_CNT = 3,
  parameter  int MAX_CNT = 5,
  parameter  int WINDOW  = 16,
  parameter  int TOT_W   = 16,
  localparam int CNT_W   = cnt_width(MAX_CNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       trig,
  input  logic [NCH-1:0]       ev,
  input  logic [NCH-1:0]       qual,
  input  logic [NCH-1:0]       mode,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       pass,
  output logic [NCH-1:0]       fail,
  output logic [2*NCH-1:0]     fail_code,
  output logic [NCH-1:0]       ovl,
  output logic [CNT_W*NCH-1:0] cnt,
  output logic [TOT_W-1:0]     pass_total,
  output logic [TOT_W-1:0]     fail_total
);

  localparam int PC_W  = $clog2(NCH + 1);
  localparam int SUM_W = TOT_W + 1;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    fail_code_e w_code;

    rep_chk_chan #(
      .MIN_CNT (MIN_CNT),
      .MAX_CNT (MAX_CNT),
      .WINDOW  (WINDOW)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .i_trig      (trig[g]),
      .i_ev        (ev[g]),
      .i_qual      (qual[g]),
      .i_mode      (mode[g]),
      .o_busy      (busy[g]),
      .o_pass      (pass[g]),
      .o_fail      (fail[g]),
      .o_fail_code (w_code),
      .o_ovl       (ovl[g]),
      .o_cnt       (cnt[g*CNT_W +: CNT_W])
    );

    assign fail_code[2*g +: 2] = w_code;
  end

  logic [PC_W-1:0]  w_pass_pop, w_fail_pop;
  logic [SUM_W-1:0] w_pass_sum, w_fail_sum;
  logic [TOT_W-1:0] r_pass_total, r_fail_total;

  always_comb begin
    w_pass_pop = '0;
    w_fail_pop = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pass_pop = w_pass_pop + PC_W'(pass[i]);
      w_fail_pop = w_fail_pop + PC_W'(fail[i]);
    end
    w_pass_sum = {1'b0, r_pass_total} + SUM_W'(w_pass_pop);
    w_fail_sum = {1'b0, r_fail_total} + SUM_W'(w_fail_pop);
  end

  // A carry out of the sum means the total would wrap; clamp to all-ones instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_total <= '0;
      r_fail_total <= '0;
    end else begin
      r_pass_total <= w_pass_sum[TOT_W] ? '1 : w_pass_sum[TOT_W-1:0];
      r_fail_total <= w_fail_sum[TOT_W] ? '1 : w_fail_sum[TOT_W-1:0];
    end
  end

  assign pass_total = r_pass_total;
  assign fail_total = r_fail_total;

endmodule

// File: tb/tb_rep_seq_checker.sv
// Self-checking bench for rep_seq_checker: directed scenarios plus randomized runs against an attempt-level model.
module tb_rep_seq_checker;

  localparam int NCH     = 2;
  localparam int MIN_CNT = 3;
  localparam int MAX_CNT = 5;
  localparam int WINDOW  = 16;
  localparam int TOT_W   = 16;
  localparam int CNT_W   = $clog2(MAX_CNT + 2);
  localparam int NMAX    = 100;
  localparam int NRUN    = 64;
`ifdef REP_CHK_QUAL_EN
  localparam bit QUAL_EN = 1'b1;
`else
  localparam bit QUAL_EN = 1'b0;
`endif

  logic                 clk  = 1'b0;
  logic                 rst  = 1'b1;
  logic [NCH-1:0]       trig = '0;
  logic [NCH-1:0]       ev   = '0;
  logic [NCH-1:0]       qual = '1;
  logic [NCH-1:0]       mode = '0;
  logic [NCH-1:0]       d_busy, d_pass, d_fail, d_ovl;
  logic [2*NCH-1:0]     d_code;
  logic [CNT_W*NCH-1:0] d_cnt;
  logic [TOT_W-1:0]     d_ptot, d_ftot;

  rep_seq_checker #(
    .NCH(NCH), .MIN_CNT(MIN_CNT), .MAX_CNT(MAX_CNT), .WINDOW(WINDOW), .TOT_W(TOT_W)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .ev(ev), .qual(qual), .mode(mode),
    .busy(d_busy), .pass(d_pass), .fail(d_fail), .fail_code(d_code), .ovl(d_ovl),
    .cnt(d_cnt), .pass_total(d_ptot), .fail_total(d_ftot)
  );

  always #5 clk = ~clk;

  int n_total  = 0;
  int n_passed = 0;

  // Stimulus per cycle, observed outputs per cycle, expected outputs per cycle.
  logic [NCH-1:0]       s_trig[NMAX], s_ev[NMAX], s_qual[NMAX], s_mode[NMAX];
  logic [NCH-1:0]       o_busy[NMAX], o_pass[NMAX], o_fail[NMAX], o_ovl[NMAX];
  logic [2*NCH-1:0]     o_code[NMAX];
  logic [CNT_W*NCH-1:0] o_cnt[NMAX];
  logic [TOT_W-1:0]     o_ptot[NMAX], o_ftot[NMAX];
  logic [NCH-1:0]       e_busy[NMAX], e_pass[NMAX], e_fail[NMAX], e_ovl[NMAX];
  logic [2*NCH-1:0]     e_code[NMAX];
  logic [CNT_W*NCH-1:0] e_cnt[NMAX];
  logic [TOT_W-1:0]     e_ptot[NMAX], e_ftot[NMAX];

  task automatic clear_stim();
    for (int c = 0; c < NMAX; c++) begin
      s_trig[c] = '0;
      s_ev[c]   = '0;
      s_qual[c] = '1;
      s_mode[c] = '0;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    trig = '0;
    ev   = '0;
    qual = '1;
    mode = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle c starts at the c-th rising edge after reset release; outputs are sampled mid-cycle.
  task automatic run(input int n, input int rst_cyc);
    do_reset();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      trig = s_trig[c];
      ev   = s_ev[c];
      qual = s_qual[c];
      mode = s_mode[c];
      if (c == rst_cyc) begin
        #1 rst = 1'b1;
      end
      @(negedge clk);
      o_busy[c] = d_busy;
      o_pass[c] = d_pass;
      o_fail[c] = d_fail;
      o_ovl[c]  = d_ovl;
      o_code[c] = d_code;
      o_cnt[c]  = d_cnt;
      o_ptot[c] = d_ptot;
      o_ftot[c] = d_ftot;
    end
    trig = '0;
    ev   = '0;
  endtask

  function automatic bit is_rise(input int ch, input int c);
    if (c == 0) return s_trig[0][ch];
    return s_trig[c][ch] && !s_trig[c-1][ch];
  endfunction

  // Attempt-level model: for each accepted trigger, scan forward through the stimulus to find the outcome.
  task automatic build_model(input int n);
    for (int c = 0; c < NMAX; c++) begin
      e_busy[c] = '0; e_pass[c] = '0; e_fail[c] = '0; e_ovl[c] = '0;
      e_code[c] = '0; e_cnt[c]  = '0; e_ptot[c] = '0; e_ftot[c] = '0;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      int cur = 0;
      int c   = 0;
      while (c < n) begin
        e_cnt[c][ch*CNT_W +: CNT_W] = CNT_W'(cur);
        if (is_rise(ch, c)) begin
          int cnt  = 0;
          int r    = c + 1;
          int code = 0;
          bit ok   = 1'b0;
          bit md   = s_mode[c][ch];
          for (int k = 0; k < WINDOW; k++) begin
            int cc = c + k;
            cnt += int'(s_ev[cc][ch]);
            e_cnt[cc+1][ch*CNT_W +: CNT_W] = CNT_W'(cnt);
            r = cc + 1;
            if (QUAL_EN && !s_qual[cc][ch]) begin code = 3; break; end
            if (!md && cnt == MAX_CNT + 1) begin code = 2; break; end
            if (md && cnt == MIN_CNT) begin ok = 1'b1; break; end
            if (k == WINDOW - 1) begin
              if (!md && cnt >= MIN_CNT) ok = 1'b1;
              else code = 1;
            end
          end
          for (int b = c + 1; b < r; b++) begin
            e_busy[b][ch] = 1'b1;
            if (is_rise(ch, b)) e_ovl[b][ch] = 1'b1;
          end
          if (ok) e_pass[r][ch] = 1'b1;
          else begin
            e_fail[r][ch] = 1'b1;
            e_code[r][2*ch +: 2] = 2'(code);
          end
          cur = cnt;
          c   = r;
        end else begin
          c++;
        end
      end
    end
    for (int c = 1; c < NMAX; c++) begin
      longint p = longint'(e_ptot[c-1]) + $countones(e_pass[c-1]);
      longint f = longint'(e_ftot[c-1]) + $countones(e_fail[c-1]);
      e_ptot[c] = (p > (2**TOT_W - 1)) ? '1 : TOT_W'(p);
      e_ftot[c] = (f > (2**TOT_W - 1)) ? '1 : TOT_W'(f);
    end
  endtask

  task automatic set_goto(input int ch);
    for (int c = 0; c < NMAX; c++) s_mode[c][ch] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      trig = NCH'($urandom); ev = NCH'($urandom); qual = NCH'($urandom); mode = NCH'($urandom);
      @(negedge clk);
      n_total++;
      if ({d_busy, d_pass, d_fail, d_ovl, d_code, d_cnt} !== '0)
        $display("FAIL reset_chan k%0d: got %h want 0", k, {d_busy, d_pass, d_fail, d_ovl, d_code, d_cnt});
      else n_passed++;
      n_total++;
      if ({d_ptot, d_ftot} !== '0) $display("FAIL reset_totals k%0d: got %h want 0", k, {d_ptot, d_ftot});
      else n_passed++;
    end
  endtask

  task automatic test_goto_pass();
    clear_stim(); set_goto(0);
    for (int c = 2; c <= 4; c++) s_trig[c][0] = 1'b1;
    s_ev[3][0] = 1'b1; s_ev[5][0] = 1'b1; s_ev[8][0] = 1'b1;
    run(24, -1);
    n_total++; if (o_busy[2][0] !== 1'b0) $display("FAIL goto_busy2: got %b want 0", o_busy[2][0]); else n_passed++;
    n_total++; if (o_busy[3][0] !== 1'b1) $display("FAIL goto_busy3: got %b want 1", o_busy[3][0]); else n_passed++;
    n_total++; if (o_pass[8] !== 2'b00) $display("FAIL goto_pass8: got %b want 00", o_pass[8]); else n_passed++;
    n_total++; if (o_pass[9] !== 2'b01) $display("FAIL goto_pass9: got %b want 01", o_pass[9]); else n_passed++;
    n_total++; if (o_busy[9][0] !== 1'b0) $display("FAIL goto_busy9: got %b want 0", o_busy[9][0]); else n_passed++;
    n_total++; if (o_cnt[9][CNT_W-1:0] !== CNT_W'(3)) $display("FAIL goto_cnt9: got %0d want 3", o_cnt[9][CNT_W-1:0]); else n_passed++;
    n_total++; if (o_ptot[9] !== 16'd0) $display("FAIL goto_ptot9: got %0d want 0", o_ptot[9]); else n_passed++;
    n_total++; if (o_ptot[10] !== 16'd1) $display("FAIL goto_ptot10: got %0d want 1", o_ptot[10]); else n_passed++;
  endtask

  task automatic test_nonconsec_pass();
    clear_stim();
    for (int c = 2; c <= 4; c++) s_trig[c] = 2'b11;
    s_ev[3] = 2'b11; s_ev[5] = 2'b11; s_ev[8][0] = 1'b1; s_ev[17][1] = 1'b1; s_ev[18][1] = 1'b1;
    run(24, -1);
    n_total++; if (o_pass[9] !== 2'b00) $display("FAIL nc_pass9: got %b want 00", o_pass[9]); else n_passed++;
    n_total++; if (o_busy[17] !== 2'b11) $display("FAIL nc_busy17: got %b want 11", o_busy[17]); else n_passed++;
    n_total++; if (o_pass[17] !== 2'b00) $display("FAIL nc_pass17: got %b want 00", o_pass[17]); else n_passed++;
    n_total++; if (o_pass[18] !== 2'b11) $display("FAIL nc_pass18: got %b want 11", o_pass[18]); else n_passed++;
    n_total++; if (o_fail[18] !== 2'b00) $display("FAIL nc_fail18: got %b want 00", o_fail[18]); else n_passed++;
    n_total++; if (o_cnt[19] !== {CNT_W'(3), CNT_W'(3)}) $display("FAIL nc_cnt19: got %h want %h", o_cnt[19], {CNT_W'(3), CNT_W'(3)}); else n_passed++;
    n_total++; if (o_ptot[19] !== 16'd2) $display("FAIL nc_ptot19: got %0d want 2", o_ptot[19]); else n_passed++;
  endtask

  task automatic test_overcount();
    clear_stim();
    s_trig[2][0] = 1'b1;
    for (int c = 3; c <= 8; c++) s_ev[c][0] = 1'b1;
    run(14, -1);
    n_total++; if (o_fail[8][0] !== 1'b0) $display("FAIL over_fail8: got %b want 0", o_fail[8][0]); else n_passed++;
    n_total++; if (o_fail[9][0] !== 1'b1) $display("FAIL over_fail9: got %b want 1", o_fail[9][0]); else n_passed++;
    n_total++; if (o_code[9][1:0] !== 2'd2) $display("FAIL over_code9: got %0d want 2", o_code[9][1:0]); else n_passed++;
    n_total++; if (o_cnt[9][CNT_W-1:0] !== CNT_W'(6)) $display("FAIL over_cnt9: got %0d want 6", o_cnt[9][CNT_W-1:0]); else n_passed++;
    n_total++; if (o_busy[9][0] !== 1'b0) $display("FAIL over_busy9: got %b want 0", o_busy[9][0]); else n_passed++;
    n_total++; if (o_ftot[10] !== 16'd1) $display("FAIL over_ftot10: got %0d want 1", o_ftot[10]); else n_passed++;
  endtask

  task automatic test_undercount();
    clear_stim(); set_goto(0);
    s_trig[2] = 2'b11;
    s_ev[3] = 2'b11; s_ev[5] = 2'b11;
    run(22, -1);
    n_total++; if (o_busy[17] !== 2'b11) $display("FAIL under_busy17: got %b want 11", o_busy[17]); else n_passed++;
    n_total++; if (o_fail[17] !== 2'b00) $display("FAIL under_fail17: got %b want 00", o_fail[17]); else n_passed++;
    n_total++; if (o_fail[18] !== 2'b11) $display("FAIL under_fail18: got %b want 11", o_fail[18]); else n_passed++;
    n_total++; if (o_code[18] !== 4'b0101) $display("FAIL under_code18: got %b want 0101", o_code[18]); else n_passed++;
    n_total++; if (o_ftot[18] !== 16'd0) $display("FAIL under_ftot18: got %0d want 0", o_ftot[18]); else n_passed++;
    n_total++; if (o_ftot[19] !== 16'd2) $display("FAIL under_ftot19: got %0d want 2", o_ftot[19]); else n_passed++;
  endtask

  task automatic test_qualifier();
    bit exp_fail7 = QUAL_EN;
    bit exp_pass9 = !QUAL_EN;
    clear_stim(); set_goto(0);
    s_trig[2][0] = 1'b1;
    s_ev[3][0] = 1'b1; s_ev[5][0] = 1'b1; s_ev[8][0] = 1'b1;
    s_qual[6][0] = 1'b0;
    s_qual[1][1] = 1'b0;
    run(14, -1);
    n_total++; if (o_fail[7][0] !== exp_fail7) $display("FAIL qual_fail7: got %b want %b", o_fail[7][0], exp_fail7); else n_passed++;
    if (exp_fail7) begin
      n_total++; if (o_code[7][1:0] !== 2'd3) $display("FAIL qual_code7: got %0d want 3", o_code[7][1:0]); else n_passed++;
    end
    n_total++; if (o_pass[9][0] !== exp_pass9) $display("FAIL qual_pass9: got %b want %b", o_pass[9][0], exp_pass9); else n_passed++;
    n_total++; if (o_fail[2][1] !== 1'b0) $display("FAIL qual_idle_ch1: got %b want 0", o_fail[2][1]); else n_passed++;
  endtask

  task automatic test_overlap();
    clear_stim(); set_goto(0);
    s_trig[2][0] = 1'b1; s_trig[5][0] = 1'b1; s_trig[6][0] = 1'b1;
    s_ev[3][0] = 1'b1; s_ev[5][0] = 1'b1; s_ev[8][0] = 1'b1;
    run(14, -1);
    n_total++; if (o_ovl[2][0] !== 1'b0) $display("FAIL ovl_start: got %b want 0", o_ovl[2][0]); else n_passed++;
    n_total++; if (o_ovl[5][0] !== 1'b1) $display("FAIL ovl_5: got %b want 1", o_ovl[5][0]); else n_passed++;
    n_total++; if (o_ovl[6][0] !== 1'b0) $display("FAIL ovl_6: got %b want 0", o_ovl[6][0]); else n_passed++;
    n_total++; if (o_pass[9][0] !== 1'b1) $display("FAIL ovl_pass9: got %b want 1", o_pass[9][0]); else n_passed++;
    n_total++; if (o_busy[10][0] !== 1'b0) $display("FAIL ovl_busy10: got %b want 0", o_busy[10][0]); else n_passed++;
  endtask

  task automatic test_reset_abort();
    logic [NCH-1:0] any_pulse = '0;
    clear_stim(); set_goto(0);
    s_trig[2][0] = 1'b1;
    s_ev[3][0] = 1'b1; s_ev[5][0] = 1'b1; s_ev[8][0] = 1'b1;
    run(14, 7);
    for (int c = 7; c < 14; c++) any_pulse = any_pulse | o_pass[c] | o_fail[c];
    n_total++; if (o_busy[6][0] !== 1'b1) $display("FAIL abort_busy6: got %b want 1", o_busy[6][0]); else n_passed++;
    n_total++; if (o_busy[7][0] !== 1'b0) $display("FAIL abort_busy7: got %b want 0", o_busy[7][0]); else n_passed++;
    n_total++; if (any_pulse !== 2'b00) $display("FAIL abort_pulses: got %b want 00", any_pulse); else n_passed++;
  endtask

  task automatic test_back_to_back();
    clear_stim(); set_goto(0);
    s_trig[2][0] = 1'b1; s_trig[9][0] = 1'b1;
    s_ev[3][0] = 1'b1; s_ev[5][0] = 1'b1; s_ev[8][0] = 1'b1; s_ev[9][0] = 1'b1;
    run(28, -1);
    n_total++; if (o_pass[9][0] !== 1'b1) $display("FAIL b2b_pass9: got %b want 1", o_pass[9][0]); else n_passed++;
    n_total++; if (o_ovl[9][0] !== 1'b0) $display("FAIL b2b_ovl9: got %b want 0", o_ovl[9][0]); else n_passed++;
    n_total++; if (o_busy[10][0] !== 1'b1) $display("FAIL b2b_busy10: got %b want 1", o_busy[10][0]); else n_passed++;
    n_total++; if (o_cnt[10][CNT_W-1:0] !== CNT_W'(1)) $display("FAIL b2b_cnt10: got %0d want 1", o_cnt[10][CNT_W-1:0]); else n_passed++;
    n_total++; if (o_fail[25][0] !== 1'b1) $display("FAIL b2b_fail25: got %b want 1", o_fail[25][0]); else n_passed++;
    n_total++; if (o_code[25][1:0] !== 2'd1) $display("FAIL b2b_code25: got %0d want 1", o_code[25][1:0]); else n_passed++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int ev_pct = 10 + 15 * r;
      clear_stim();
      for (int c = 0; c < NRUN; c++)
        for (int ch = 0; ch < NCH; ch++) begin
          s_trig[c][ch] = ($urandom_range(0, 99) < 35);
          s_ev[c][ch]   = ($urandom_range(0, 99) < ev_pct);
          s_qual[c][ch] = ($urandom_range(0, 99) < 96);
          s_mode[c][ch] = $urandom_range(0, 1) == 1;
        end
      build_model(NRUN);
      run(NRUN, -1);
      for (int c = 0; c < NRUN; c++) begin
        n_total++; if (o_busy[c] !== e_busy[c]) $display("FAIL rnd%0d c%0d busy: got %b want %b", r, c, o_busy[c], e_busy[c]); else n_passed++;
        n_total++; if (o_pass[c] !== e_pass[c]) $display("FAIL rnd%0d c%0d pass: got %b want %b", r, c, o_pass[c], e_pass[c]); else n_passed++;
        n_total++; if (o_fail[c] !== e_fail[c]) $display("FAIL rnd%0d c%0d fail: got %b want %b", r, c, o_fail[c], e_fail[c]); else n_passed++;
        n_total++; if (o_ovl[c] !== e_ovl[c]) $display("FAIL rnd%0d c%0d ovl: got %b want %b", r, c, o_ovl[c], e_ovl[c]); else n_passed++;
        n_total++; if (o_cnt[c] !== e_cnt[c]) $display("FAIL rnd%0d c%0d cnt: got %h want %h", r, c, o_cnt[c], e_cnt[c]); else n_passed++;
        n_total++; if (o_ptot[c] !== e_ptot[c]) $display("FAIL rnd%0d c%0d pass_total: got %0d want %0d", r, c, o_ptot[c], e_ptot[c]); else n_passed++;
        n_total++; if (o_ftot[c] !== e_ftot[c]) $display("FAIL rnd%0d c%0d fail_total: got %0d want %0d", r, c, o_ftot[c], e_ftot[c]); else n_passed++;
        for (int ch = 0; ch < NCH; ch++)
          if (e_fail[c][ch]) begin
            n_total++;
            if (o_code[c][2*ch +: 2] !== e_code[c][2*ch +: 2])
              $display("FAIL rnd%0d c%0d ch%0d code: got %0d want %0d", r, c, ch, o_code[c][2*ch +: 2], e_code[c][2*ch +: 2]);
            else n_passed++;
          end
      end
    end
  endtask

  initial begin
    test_reset();
    test_goto_pass();
    test_nonconsec_pass();
    test_overcount();
    test_undercount();
    test_qualifier();
    test_overlap();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
